// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, captures imem words into a prefetch FIFO for decode.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module if_fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       DEPTH    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [31:0]       i_imem_inst,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       o_fetch_cnt,
  output logic [31:0]       o_bubble_cnt,
  output logic [31:0]       o_flush_cnt,
`endif
  output logic [ADDR_W-1:0] o_pc_plus4
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [31:0]       mem_inst [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              pop;
  logic              push;

  assign o_imem_addr = fetch_pc;
  assign o_valid     = (count != '0) & ~i_redirect;
  assign pop         = o_valid & i_ready;
  assign push        = ~i_redirect & ((count != DEPTH_C) | pop);

  assign o_pc       = mem_pc[rd_ptr];
  assign o_pc_plus4 = o_pc + ADDR_W'(4);
  assign o_inst     = o_valid ? mem_inst[rd_ptr] : NOP;

  // PC storage is cleared on reset so o_pc reads 0 before the first fetch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc <= RESET_PC & ALIGN_MASK;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_pc   <= '{default: '0};
    end else if (i_redirect) begin
      fetch_pc <= i_redirect_pc & ALIGN_MASK;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]   <= fetch_pc;
        mem_inst[wr_ptr] <= i_imem_inst;
        wr_ptr           <= wr_ptr + PW'(1);
        fetch_pc         <= fetch_pc + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fetch_cnt  <= '0;
      o_bubble_cnt <= '0;
      o_flush_cnt  <= '0;
    end else begin
      if (pop) begin
        o_fetch_cnt <= o_fetch_cnt + 32'd1;
      end
      if (i_ready & ~o_valid) begin
        o_bubble_cnt <= o_bubble_cnt + 32'd1;
      end
      // Everything still queued at a redirect is thrown away.
      if (i_redirect) begin
        o_flush_cnt <= o_flush_cnt + 32'(count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: scoreboard of expected PCs plus directed scenarios.
// A second instance with RESET_PC near the top of the address space covers PC wraparound.
module tb_if_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, redirect, ready;
  logic [31:0] redirect_pc, imem_addr, imem_inst, o_inst, o_pc, o_pc_plus4;
  logic        o_valid;

  logic        w_valid;
  logic        w_ready = 1'b1;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic [31:0] w_addr, w_imem, w_inst, w_pc, w_plus4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt, flush_cnt;
  logic [31:0] w_fetch_cnt, w_bubble_cnt, w_flush_cnt;
`endif

  always #5 clk = ~clk;

  assign imem_inst = {2'b00, imem_addr[31:2]};
  assign w_imem    = {2'b00, w_addr[31:2]};

  if_fetch_queue #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .o_imem_addr(imem_addr), .i_imem_inst(imem_inst),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_valid(o_valid),
    .i_ready(ready), .o_inst(o_inst), .o_pc(o_pc),
`ifdef FETCH_PERF_CNT_EN
    .o_fetch_cnt(fetch_cnt), .o_bubble_cnt(bubble_cnt), .o_flush_cnt(flush_cnt),
`endif
    .o_pc_plus4(o_pc_plus4)
  );

  if_fetch_queue #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .i_clk(clk), .i_rst(rst), .o_imem_addr(w_addr), .i_imem_inst(w_imem),
    .i_redirect(w_redirect), .i_redirect_pc(w_redirect_pc), .o_valid(w_valid),
    .i_ready(w_ready), .o_inst(w_inst), .o_pc(w_pc),
`ifdef FETCH_PERF_CNT_EN
    .o_fetch_cnt(w_fetch_cnt), .o_bubble_cnt(w_bubble_cnt), .o_flush_cnt(w_flush_cnt),
`endif
    .o_pc_plus4(w_plus4)
  );

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // Scoreboard: PCs the fetch stage should have queued, in order.
  logic [31:0] exp_q[$];
  logic [31:0] m_pc = 32'h0;
  bit          known = 1'b0;
  logic [31:0] m_fetch = 0, m_bubble = 0, m_flush = 0;

  // Compares outputs against the scoreboard, advances the model, then crosses one rising edge.
  task automatic cycle();
    logic        exp_valid;
    logic        pop;
    logic [31:0] head;
    #1;
    exp_valid = (exp_q.size() != 0) && !redirect;
    pop = exp_valid & ready;
    if (known) begin
      total_cnt++;
      if (o_valid !== exp_valid) $display("FAIL sb_valid got %b expected %b at %0t", o_valid, exp_valid, $time);
      else pass_cnt++;
      total_cnt++;
      if (imem_addr !== m_pc) $display("FAIL sb_imem_addr got %h expected %h at %0t", imem_addr, m_pc, $time);
      else pass_cnt++;
      if (exp_valid) begin
        head = exp_q[0];
        total_cnt++;
        if (o_pc !== head) $display("FAIL sb_pc got %h expected %h at %0t", o_pc, head, $time);
        else pass_cnt++;
        total_cnt++;
        if (o_inst !== {2'b00, head[31:2]}) $display("FAIL sb_inst got %h expected %h at %0t", o_inst, {2'b00, head[31:2]}, $time);
        else pass_cnt++;
        total_cnt++;
        if (o_pc_plus4 !== head + 32'd4) $display("FAIL sb_pc_plus4 got %h expected %h at %0t", o_pc_plus4, head + 32'd4, $time);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (o_inst !== NOP) $display("FAIL sb_nop got %h expected %h at %0t", o_inst, NOP, $time);
        else pass_cnt++;
      end
    end
    if (rst) begin
      exp_q.delete();
      m_pc = 32'h0;
      m_fetch = 0; m_bubble = 0; m_flush = 0;
      known = 1'b1;
    end else if (known) begin
      if (ready && !exp_valid) m_bubble++;
      if (redirect) begin
        m_flush += exp_q.size();
        exp_q.delete();
        m_pc = redirect_pc & ~32'd3;
      end else begin
        logic push;
        push = (exp_q.size() < 4) || pop;
        if (pop) begin
          void'(exp_q.pop_front());
          m_fetch++;
        end
        if (push) begin
          exp_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    do_reset();
    #1;
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b expected 0", o_valid); else pass_cnt++;
    total_cnt++; if (o_inst !== NOP) $display("FAIL reset_inst got %h expected %h", o_inst, NOP); else pass_cnt++;
    total_cnt++; if (o_pc !== 32'h0) $display("FAIL reset_pc got %h expected 0", o_pc); else pass_cnt++;
    total_cnt++; if (o_pc_plus4 !== 32'h4) $display("FAIL reset_pc_plus4 got %h expected 4", o_pc_plus4); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0) $display("FAIL reset_imem_addr got %h expected 0", imem_addr); else pass_cnt++;
  endtask

  task automatic test_stream();
    ready = 1'b1;
    cycle();
    for (int i = 0; i < 6; i++) begin
      total_cnt++; if (o_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b expected 1", i, o_valid); else pass_cnt++;
      total_cnt++; if (o_pc !== 32'(4 * i)) $display("FAIL stream_pc[%0d] got %h expected %h", i, o_pc, 32'(4 * i)); else pass_cnt++;
      total_cnt++; if (o_inst !== 32'(i)) $display("FAIL stream_inst[%0d] got %h expected %h", i, o_inst, 32'(i)); else pass_cnt++;
      cycle();
    end
  endtask

  task automatic test_fill();
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    total_cnt++; if (imem_addr !== 32'h10) $display("FAIL fill_imem_addr got %h expected 10", imem_addr); else pass_cnt++;
    total_cnt++; if (o_pc !== 32'h0) $display("FAIL fill_head_pc got %h expected 0", o_pc); else pass_cnt++;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++; if (o_valid !== 1'b1) $display("FAIL drain_valid[%0d] got %b expected 1", i, o_valid); else pass_cnt++;
      total_cnt++; if (o_pc !== 32'(4 * i)) $display("FAIL drain_pc[%0d] got %h expected %h", i, o_pc, 32'(4 * i)); else pass_cnt++;
      cycle();
      if (i == 0) begin
        total_cnt++; if (imem_addr !== 32'h14) $display("FAIL full_pushpop_addr got %h expected 14", imem_addr); else pass_cnt++;
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    redirect = 1'b1; redirect_pc = 32'h203;
    #1;
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL redir_cycle_valid got %b expected 0", o_valid); else pass_cnt++;
    cycle();
    redirect = 1'b0; ready = 1'b1;
    #1;
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL redir_next_valid got %b expected 0", o_valid); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h200) $display("FAIL redir_addr got %h expected 200", imem_addr); else pass_cnt++;
`ifdef FETCH_PERF_CNT_EN
    total_cnt++; if (flush_cnt !== 32'd3) $display("FAIL flush_cnt got %0d expected 3", flush_cnt); else pass_cnt++;
`endif
    cycle();
    total_cnt++; if (o_valid !== 1'b1) $display("FAIL redir_valid got %b expected 1", o_valid); else pass_cnt++;
    total_cnt++; if (o_pc !== 32'h200) $display("FAIL redir_pc got %h expected 200", o_pc); else pass_cnt++;
    total_cnt++; if (o_inst !== 32'h80) $display("FAIL redir_inst got %h expected 80", o_inst); else pass_cnt++;
    cycle();
    total_cnt++; if (o_pc !== 32'h204) $display("FAIL redir_pc2 got %h expected 204", o_pc); else pass_cnt++;
  endtask

  task automatic test_reset_full();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h400;
    cycle();
    rst = 1'b0; redirect = 1'b0;
    #1;
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL rstfull_valid got %b expected 0", o_valid); else pass_cnt++;
    total_cnt++; if (o_inst !== NOP) $display("FAIL rstfull_inst got %h expected %h", o_inst, NOP); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0) $display("FAIL rstfull_addr got %h expected 0", imem_addr); else pass_cnt++;
    cycle();
  endtask

  task automatic test_wrap();
    ready = 1'b1;
    do_reset();
    #1;
    total_cnt++; if (w_valid !== 1'b0) $display("FAIL wrap_reset_valid got %b expected 0", w_valid); else pass_cnt++;
    cycle();
    total_cnt++; if (w_pc !== 32'hFFFF_FFF8) $display("FAIL wrap_pc0 got %h expected fffffff8", w_pc); else pass_cnt++;
    total_cnt++; if (w_inst !== 32'h3FFF_FFFE) $display("FAIL wrap_inst0 got %h expected 3ffffffe", w_inst); else pass_cnt++;
    cycle();
    total_cnt++; if (w_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc1 got %h expected fffffffc", w_pc); else pass_cnt++;
    total_cnt++; if (w_plus4 !== 32'h0) $display("FAIL wrap_plus4 got %h expected 0", w_plus4); else pass_cnt++;
    cycle();
    total_cnt++; if (w_pc !== 32'h0) $display("FAIL wrap_pc2 got %h expected 0", w_pc); else pass_cnt++;
    total_cnt++; if (w_valid !== 1'b1) $display("FAIL wrap_valid got %b expected 1", w_valid); else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 80; i++) begin
      ready = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom & 32'h0000_0FFF;
      cycle();
    end
    redirect = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    total_cnt++; if (fetch_cnt !== m_fetch) $display("FAIL fetch_cnt got %0d expected %0d", fetch_cnt, m_fetch); else pass_cnt++;
    total_cnt++; if (bubble_cnt !== m_bubble) $display("FAIL bubble_cnt got %0d expected %0d", bubble_cnt, m_bubble); else pass_cnt++;
    total_cnt++; if (flush_cnt !== m_flush) $display("FAIL flush_total got %0d expected %0d", flush_cnt, m_flush); else pass_cnt++;
`endif
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_fill();
    test_redirect();
    test_reset_full();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction fetch stage sitting directly upstream of the instruction memory and downstream-feeding the decode stage. Owns the fetch PC, drives the word address to the asynchronous-read instruction memory, and captures each returned instruction with its PC into a small prefetch FIFO. Decode consumes entries through a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and restart fetch at the target.

Parameters:
ADDR_W, 32, PC/address width in bits
RESET_PC, 32'h0000_0000, fetch PC after reset; bits [1:0] are ignored and treated as 0
DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous reset, active-high
o_imem_addr  output  ADDR_W  byte address to instruction memory; always equals fetch_pc
i_imem_inst  input  32  instruction word returned combinationally for o_imem_addr in the same cycle
i_redirect  input  1  flush and restart fetch (taken branch/jump)
i_redirect_pc  input  ADDR_W  restart target; bits [1:0] forced to 0
o_valid  output  1  head entry available to decode
i_ready  input  1  decode accepts head entry this cycle
o_inst  output  32  head instruction; 32'h0000_0013 (NOP) when o_valid=0
o_pc  output  ADDR_W  PC of head instruction
o_pc_plus4  output  ADDR_W  o_pc + 4, modulo 2^ADDR_W

Behaviour:
- State: fetch_pc (ADDR_W), storage DEPTH x {pc, inst}, wr_ptr/rd_ptr ($clog2(DEPTH) bits), count ($clog2(DEPTH)+1 bits).
- Reset (i_rst=1 at edge): fetch_pc <= {RESET_PC[ADDR_W-1:2],2'b00}; count, wr_ptr, rd_ptr <= 0; storage contents don't-care. After reset: o_valid=0, o_inst=NOP, o_pc=0, o_pc_plus4=4. Reset overrides redirect, push and pop. Reset mid-stream discards all queued entries.
- pop = o_valid & i_ready.
- push = !i_redirect & ((count < DEPTH) | pop). A full FIFO may push and pop in the same cycle; count is unchanged.
- On push: storage[wr_ptr] <= {fetch_pc, i_imem_inst}; wr_ptr++ (wraps at DEPTH); fetch_pc <= fetch_pc + 4 (wraps modulo 2^ADDR_W, 0xFFFF_FFFC -> 0x0).
- On pop: rd_ptr++ (wraps); count-- unless push in the same cycle.
- No push: fetch_pc holds (stall). i_imem_inst is sampled only on a push.
- Redirect has top priority below reset. On the edge: count, wr_ptr, rd_ptr <= 0; fetch_pc <= {i_redirect_pc[ADDR_W-1:2],2'b00}; no push.
- o_valid = (count != 0) & !i_redirect. The consumer never sees a pop during a redirect cycle.
- o_inst and o_pc come from storage[rd_ptr] (registered data, no combinational path from i_imem_inst). o_inst is forced to NOP when o_valid=0.
- Latency: the first instruction after reset or redirect is pushed on the first clock edge and valid on the following cycle. Redirect-to-valid takes 2 cycles: the redirect cycle, then the push cycle.
- Steady state with i_ready held 1 gives 1 instruction per cycle with consecutive PCs.
- With i_ready held 0, the FIFO fills in DEPTH cycles, then fetch_pc stops at first_pc + 4*DEPTH.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs o_fetch_cnt[31:0] (pops), o_bubble_cnt[31:0] (cycles with i_ready=1, o_valid=0, i_rst=0) and o_flush_cnt[31:0] (entries discarded by redirect; adds count at the redirect edge).
- All three counters reset to 0 on i_rst and wrap at 2^32.
- Not defined: these ports and their logic do not exist. Core behaviour is identical either way.

Test Plan:
- Reset, imem model mem[n]=n, i_ready=1 -> cycle 1: o_valid=1, o_pc=0x0, o_inst=0; then o_pc=0x4,0x8,... one per cycle; o_pc_plus4=o_pc+4.
- i_ready=0 for 10 cycles after reset with DEPTH=4 -> count reaches 4, o_imem_addr stops at 0x10, o_pc stays 0x0; i_ready=1 -> pops 0x0,0x4,0x8,0xC,0x10 with no gap.
- Full FIFO with i_ready=1 for one cycle -> simultaneous push/pop, count stays 4, fetch_pc advances 0x10->0x14.
- i_redirect=1, i_redirect_pc=0x203 with 3 entries queued -> o_valid=0 in the redirect cycle and the next; then o_pc=0x200. The stale entries never appear. With FETCH_PERF_CNT_EN: o_flush_cnt += 3.
- RESET_PC=0xFFFF_FFF8, i_ready=1 -> o_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; o_pc_plus4 at 0xFFFF_FFFC is 0x0.
- Assert i_rst together with i_redirect while the FIFO is full -> next cycle count=0, o_valid=0, o_inst=NOP, o_imem_addr=RESET_PC.
